// File: rtl/clcd_bus_arbiter_pkg.sv
// Shared types and constants for the CLCD byte-channel arbiter.
package clcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    SETTLE
  } arb_state_e;

  localparam logic [7:0]  CMD_CLEAR = 8'h01;
  localparam logic [7:0]  CMD_HOME  = 8'h02;
  localparam int unsigned N_REQ_DEF = 3;
  localparam int unsigned REQ_INIT  = 0;

  // Clear, home and the 8'h03 home alias need the long LCD settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/clcd_bus_arbiter_if.sv
// Byte-write channel between the arbiter (master) and the I2C CLCD byte driver (slave).
interface clcd_bus_arbiter_if;
  logic [7:0] o_data;
  logic       o_RS;
  logic       o_RW;
  logic       o_valid;
  logic       i_busy;

  modport master (output o_data, o_RS, o_RW, o_valid, input i_busy);
  modport slave  (input o_data, o_RS, o_RW, o_valid, output i_busy);
endinterface

// File: rtl/clcd_bus_arbiter_us_tick.sv
// Free-running CLK_HZ/1_000_000 divider: one-cycle pulse every microsecond.
module clcd_us_tick #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int unsigned DIV = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == DW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DW'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/clcd_bus_arbiter.sv
// Arbitrates the single CLCD byte channel among N_REQ requesters (index 0 = init sequencer).
// Define CLCD_ARB_TIMEOUT_EN to enable the busy watchdog; otherwise o_timeout stays 0.
module clcd_bus_arbiter
  import clcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned CMD_DLY_US = 50,
  parameter int unsigned CLR_DLY_US = 2000,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_init_done,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ-1:0]     i_req_lock,
  input  logic [8*N_REQ-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_rs,
  input  logic [N_REQ-1:0]     i_req_rw,
  output logic [N_REQ-1:0]     o_req_ack,
  output logic [N_REQ-1:0]     o_grant,
  clcd_bus_arbiter_if.master   drv,
  output logic                 o_idle,
  output logic                 o_timeout
);
  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DM0  = (CLR_DLY_US > CMD_DLY_US) ? CLR_DLY_US : CMD_DLY_US;
  localparam int unsigned DMAX = (TIMEOUT_US > DM0) ? TIMEOUT_US : DM0;
  localparam int unsigned CW   = $clog2(DMAX + 1);
  localparam logic [N_REQ-1:0] INIT_MASK = N_REQ'(1) << REQ_INIT;

  arb_state_e     state;
  logic [IW-1:0]  owner, rr_ptr, rr_next, win_idx, sel_idx;
  logic [IW:0]    cand;
  logic [N_REQ-1:0] elig;
  logic           win_vld;
  logic [CW-1:0]  settle;
  logic [7:0]     data_q, sel_data;
  logic           rs_q, rw_q, valid_q;
  logic           busy_q1, busy_q2, busy_rise, busy_fall;
  logic           us_tick, wd_expired;

  clcd_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (us_tick)
  );

  assign drv.o_data  = data_q;
  assign drv.o_RS    = rs_q;
  assign drv.o_RW    = rw_q;
  assign drv.o_valid = valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q1 <= 1'b0;
      busy_q2 <= 1'b0;
    end else begin
      busy_q1 <= drv.i_busy;
      busy_q2 <= busy_q1;
    end
  end
  assign busy_rise = busy_q1 & ~busy_q2;
  assign busy_fall = ~busy_q1 & busy_q2;

  // Requester 0 wins outright; the rest are scanned starting at rr_ptr, wrapping within 1..N_REQ-1.
  always_comb begin
    elig    = i_init_done ? i_req_valid : (i_req_valid & INIT_MASK);
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (elig[REQ_INIT]) begin
      win_vld = 1'b1;
      win_idx = IW'(REQ_INIT);
    end else begin
      for (int unsigned k = 0; k < N_REQ - 1; k++) begin
        cand = {1'b0, rr_ptr} + (IW+1)'(k);
        if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ - 1);
        if (!win_vld && elig[cand[IW-1:0]]) begin
          win_vld = 1'b1;
          win_idx = cand[IW-1:0];
        end
      end
    end
    rr_next  = (win_idx == IW'(N_REQ - 1)) ? IW'(1) : win_idx + IW'(1);
    sel_idx  = (state == SETTLE) ? owner : win_idx;
    sel_data = i_req_data[8*sel_idx +: 8];
  end

`ifdef CLCD_ARB_TIMEOUT_EN
  logic [CW-1:0] wd_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wd_cnt <= '0;
    else if (state == ISSUE || state == WAIT_DONE) begin
      if (us_tick && !wd_expired) wd_cnt <= wd_cnt + CW'(1);
    end else
      wd_cnt <= '0;
  end
  assign wd_expired = (wd_cnt == CW'(TIMEOUT_US));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      o_grant   <= '0;
      o_req_ack <= '0;
      o_idle    <= 1'b1;
      o_timeout <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      valid_q   <= 1'b0;
      owner     <= '0;
      rr_ptr    <= IW'(1);
      settle    <= '0;
    end else begin
      o_req_ack <= '0;
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            o_grant <= N_REQ'(1) << win_idx;
            owner   <= win_idx;
            data_q  <= sel_data;
            rs_q    <= i_req_rs[sel_idx];
            rw_q    <= i_req_rw[sel_idx];
            valid_q <= 1'b1;
            o_idle  <= 1'b0;
            if (win_idx != IW'(REQ_INIT)) rr_ptr <= rr_next;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          if (wd_expired) begin
            valid_q   <= 1'b0;
            o_timeout <= 1'b1;
            o_req_ack <= o_grant;
            settle    <= CW'(CLR_DLY_US);
            state     <= SETTLE;
          end else if (state == ISSUE && busy_rise) begin
            valid_q <= 1'b0;
            state   <= WAIT_DONE;
          end else if (state == WAIT_DONE && busy_fall) begin
            o_req_ack <= o_grant;
            settle    <= is_long_cmd(rs_q, data_q) ? CW'(CLR_DLY_US) : CW'(CMD_DLY_US);
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle != '0) begin
            if (us_tick) settle <= settle - CW'(1);
          end else if (elig[owner] && i_req_lock[owner]) begin
            data_q  <= sel_data;
            rs_q    <= i_req_rs[sel_idx];
            rw_q    <= i_req_rw[sel_idx];
            valid_q <= 1'b1;
            state   <= ISSUE;
          end else begin
            o_grant <= '0;
            o_idle  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clcd_bus_arbiter.sv
// Directed bench for clcd_bus_arbiter with scaled timing (10 clocks per microsecond).
module tb_clcd_bus_arbiter;
  logic        clk;
  logic        reset_n;
  logic        init_done;
  logic [2:0]  req_valid, req_lock, req_rs, req_rw;
  logic [23:0] req_data;
  logic [2:0]  ack, grant;
  logic        idle, timeout;

  clcd_bus_arbiter_if bus();

  clcd_bus_arbiter #(
    .CLK_HZ    (10_000_000),
    .N_REQ     (3),
    .CMD_DLY_US(5),
    .CLR_DLY_US(20),
    .TIMEOUT_US(10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_init_done(init_done),
    .i_req_valid(req_valid),
    .i_req_lock (req_lock),
    .i_req_data (req_data),
    .i_req_rs   (req_rs),
    .i_req_rw   (req_rw),
    .o_req_ack  (ack),
    .o_grant    (grant),
    .drv        (bus),
    .o_idle     (idle),
    .o_timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, last_fall = 0, t_valid = 0;
  int unsigned ack_cnt = 0, dbl_ack = 0, to_cnt = 0, to_cyc = 0;
  logic [2:0]  to_ack, ack_prev;
  logic        to_vld, vld_prev, drv_en;
  int unsigned drv_phase = 0, drv_cnt = 0;
  logic [2:0]  g_q[$];
  logic [7:0]  d_q[$];
  int unsigned gap_q[$];
  logic [8:0]  scr[3][3];
  int unsigned len[3], pos[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic post(input int unsigned i, input int unsigned n,
                      input logic [8:0] b0, input logic [8:0] b1, input logic [8:0] b2,
                      input logic lk);
    scr[i][0] = b0; scr[i][1] = b1; scr[i][2] = b2;
    len[i] = n; pos[i] = 0;
    req_data[8*i +: 8] = b0[7:0];
    req_rs[i]    = b0[8];
    req_lock[i]  = lk;
    req_valid[i] = 1'b1;
  endtask

  // One negedge: monitor, requester scripts, and the busy-driver model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.o_valid && !vld_prev) begin
      g_q.push_back(grant);
      d_q.push_back(bus.o_data);
      gap_q.push_back(cyc - last_fall);
      t_valid = cyc;
    end
    vld_prev = bus.o_valid;
    if (timeout) begin
      to_cnt++; to_cyc = cyc; to_ack = ack; to_vld = bus.o_valid;
    end
    if (ack != 3'b000) begin
      ack_cnt++;
      if (ack == ack_prev) dbl_ack++;
      for (int i = 0; i < 3; i++) begin
        if (ack[i] && req_valid[i]) begin
          pos[i]++;
          if (pos[i] >= len[i]) begin
            req_valid[i] = 1'b0;
            req_lock[i]  = 1'b0;
          end else begin
            req_data[8*i +: 8] = scr[i][pos[i]][7:0];
            req_rs[i] = scr[i][pos[i]][8];
          end
        end
      end
    end
    ack_prev = ack;
    case (drv_phase)
      0: if (drv_en && bus.o_valid) begin drv_phase = 1; drv_cnt = 2; end
      1: begin
        drv_cnt--;
        if (drv_cnt == 0) begin bus.i_busy = 1'b1; drv_cnt = 40; drv_phase = 2; end
      end
      default: begin
        drv_cnt--;
        if (drv_cnt == 0) begin bus.i_busy = 1'b0; last_fall = cyc; drv_phase = 0; end
      end
    endcase
  endtask

  task automatic wait_grants(input string tag, input int unsigned n, input int unsigned limit);
    for (int unsigned i = 0; i < limit && g_q.size() < n; i++) step();
    check_val(tag, 32'(g_q.size() >= n), 32'd1);
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; init_done = 1'b0; drv_en = 1'b1;
    req_valid = '0; req_lock = '0; req_rs = '0; req_rw = '0; req_data = '0;
    bus.i_busy = 1'b0; vld_prev = 1'b0; ack_prev = '0; to_ack = '0; to_vld = 1'b0;
    steps(3);
    check_val("rst_valid", 32'(bus.o_valid), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_idle", 32'(idle), 32'd1);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_data", 32'(bus.o_data), 32'd0);
    reset_n = 1'b1;
    steps(2);

    // Init phase: only requester 0 may be served; clear/home settle is long.
    post(0, 3, {1'b0, 8'h01}, {1'b0, 8'h28}, {1'b0, 8'h38}, 1'b0);
    post(1, 1, {1'b1, 8'h41}, 9'h000, 9'h000, 1'b0);
    wait_grants("init_wait", 3, 1500);
    steps(200);
    check_val("init_count", g_q.size(), 32'd3);
    check_val("init_g0", 32'(g_q[0]), 32'h1);
    check_val("init_g2", 32'(g_q[2]), 32'h1);
    check_val("init_d0", 32'(d_q[0]), 32'h01);
    check_val("init_d1", 32'(d_q[1]), 32'h28);
    check_val("clr_gap_min", 32'(gap_q[1] >= 190), 32'd1);
    check_val("clr_gap_max", 32'(gap_q[1] <= 215), 32'd1);
    check_val("cmd_gap_min", 32'(gap_q[2] >= 40), 32'd1);
    check_val("cmd_gap_max", 32'(gap_q[2] <= 60), 32'd1);
    init_done = 1'b1;
    wait_grants("init_rel_wait", 4, 300);
    check_val("init_rel_g", 32'(g_q[3]), 32'h2);
    check_val("init_rel_d", 32'(d_q[3]), 32'h41);
    steps(150);

    // Fresh reset so the round-robin pointer starts at requester 1.
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
    g_q.delete(); d_q.delete(); gap_q.delete();
    post(1, 2, {1'b1, 8'h61}, {1'b1, 8'h62}, 9'h000, 1'b0);
    post(2, 2, {1'b1, 8'h71}, {1'b1, 8'h72}, 9'h000, 1'b0);
    wait_grants("rr_wait", 4, 2000);
    check_val("rr_g0", 32'(g_q[0]), 32'h2);
    check_val("rr_g1", 32'(g_q[1]), 32'h4);
    check_val("rr_g2", 32'(g_q[2]), 32'h2);
    check_val("rr_g3", 32'(g_q[3]), 32'h4);
    check_val("rr_d3", 32'(d_q[3]), 32'h72);
    steps(150);
    post(1, 1, {1'b1, 8'h63}, 9'h000, 9'h000, 1'b0);
    post(2, 1, {1'b1, 8'h73}, 9'h000, 9'h000, 1'b0);
    wait_grants("pre_wait1", 5, 300);
    post(0, 1, {1'b1, 8'h5A}, 9'h000, 9'h000, 1'b0);
    wait_grants("pre_wait2", 7, 1000);
    check_val("pre_g4", 32'(g_q[4]), 32'h2);
    check_val("pre_g5", 32'(g_q[5]), 32'h1);
    check_val("pre_g6", 32'(g_q[6]), 32'h4);
    steps(150);

    // Locked string from requester 2 must not be interleaved by requester 1.
    post(2, 3, {1'b0, 8'hC0}, {1'b1, 8'h31}, {1'b1, 8'h32}, 1'b1);
    wait_grants("lock_wait1", 8, 300);
    post(1, 1, {1'b1, 8'h42}, 9'h000, 9'h000, 1'b0);
    wait_grants("lock_wait2", 11, 1500);
    check_val("lock_g7", 32'(g_q[7]), 32'h4);
    check_val("lock_g8", 32'(g_q[8]), 32'h4);
    check_val("lock_g9", 32'(g_q[9]), 32'h4);
    check_val("lock_g10", 32'(g_q[10]), 32'h2);
    check_val("lock_d7", 32'(d_q[7]), 32'hC0);
    check_val("lock_d8", 32'(d_q[8]), 32'h31);
    check_val("lock_d9", 32'(d_q[9]), 32'h32);
    check_val("lock_d10", 32'(d_q[10]), 32'h42);
    steps(150);

    // Reset while the driver is busy (arbiter in WAIT_DONE).
    post(1, 1, {1'b1, 8'h43}, 9'h000, 9'h000, 1'b0);
    for (int unsigned i = 0; i < 300 && !(drv_phase == 2 && !bus.o_valid); i++) step();
    check_val("mid_reached", 32'(drv_phase == 2 && !bus.o_valid), 32'd1);
    steps(5);
    check_val("mid_grant_pre", 32'(grant), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    check_val("mid_rst_grant", 32'(grant), 32'd0);
    check_val("mid_rst_idle", 32'(idle), 32'd1);
    begin
      int unsigned ack_snap, g_snap;
      ack_snap = ack_cnt;
      g_snap   = g_q.size();
      req_valid[1] = 1'b0;
      steps(3);
      reset_n = 1'b1;
      steps(100);
      check_val("mid_no_ack", ack_cnt, ack_snap);
      check_val("mid_no_grant", g_q.size(), g_snap);
      check_val("mid_idle_after", 32'(idle), 32'd1);
    end

`ifdef CLCD_ARB_TIMEOUT_EN
    drv_en = 1'b0;
    post(0, 1, {1'b0, 8'h05}, 9'h000, 9'h000, 1'b0);
    for (int unsigned i = 0; i < 400 && to_cnt == 0; i++) step();
    check_val("wd_fired", 32'(to_cnt > 0), 32'd1);
    check_val("wd_delay_min", 32'(to_cyc - t_valid >= 85), 32'd1);
    check_val("wd_delay_max", 32'(to_cyc - t_valid <= 115), 32'd1);
    check_val("wd_ack", 32'(to_ack), 32'h1);
    check_val("wd_valid", 32'(to_vld), 32'd0);
    steps(50);
    check_val("wd_single", to_cnt, 32'd1);
`else
    check_val("no_timeout", to_cnt, 32'd0);
`endif
    check_val("ack_one_cycle", dbl_ack, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
